// File: rtl/calc_sequencer.sv
// Keypad calculator controller: operand/operator entry, ALU start/done sequencing,
// serial binary-to-BCD conversion and display buffer generation.
module calc_sequencer #(
    parameter int MAX_DIGITS  = 3,
    parameter int ALU_TIMEOUT = 1024
) (
    input  logic        clock_50m,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [15:0] key_code,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [9:0]  alu_a,
    output logic [9:0]  alu_b,
    input  logic        alu_done,
    input  logic [19:0] alu_result,
    input  logic        alu_neg,
    input  logic        alu_err,
    output logic [23:0] disp_bcd,
    output logic [5:0]  disp_blank,
    output logic [1:0]  disp_mode,
    output logic [2:0]  disp_op,
    output logic        disp_neg,
    output logic        busy
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {ENTER_A, ENTER_B, EXEC, CONV, SHOW, ERR} state_t;

    state_t        state_reg;
    logic [9:0]    a_reg, b_reg;
    logic [CW-1:0] a_cnt_reg, b_cnt_reg;
    logic [2:0]    op_reg;
    logic [23:0]   entry_bcd_reg;
    logic [TW-1:0] timer_reg;
    logic [19:0]   res_reg;
    logic          res_neg_reg;
    logic [19:0]   dd_bin_reg;
    logic [23:0]   dd_bcd_reg;
    logic [4:0]    dd_cnt_reg;

    logic          key_is_digit, key_is_op, key_is_eq;
    logic [3:0]    key_digit;
    logic [2:0]    key_op;
    logic [23:0]   entry_next, dd_adj, dd_bcd_next;

    always_comb begin
        key_is_digit = 1'b0;
        key_is_op    = 1'b0;
        key_is_eq    = 1'b0;
        key_digit    = 4'd0;
        key_op       = 3'd0;
        if (key_valid) begin
            case (key_code)
                16'h2000: begin key_is_digit = 1'b1; key_digit = 4'd0; end
                16'h0001: begin key_is_digit = 1'b1; key_digit = 4'd1; end
                16'h0002: begin key_is_digit = 1'b1; key_digit = 4'd2; end
                16'h0004: begin key_is_digit = 1'b1; key_digit = 4'd3; end
                16'h0010: begin key_is_digit = 1'b1; key_digit = 4'd4; end
                16'h0020: begin key_is_digit = 1'b1; key_digit = 4'd5; end
                16'h0040: begin key_is_digit = 1'b1; key_digit = 4'd6; end
                16'h0100: begin key_is_digit = 1'b1; key_digit = 4'd7; end
                16'h0200: begin key_is_digit = 1'b1; key_digit = 4'd8; end
                16'h0400: begin key_is_digit = 1'b1; key_digit = 4'd9; end
                16'h0008: begin key_is_op = 1'b1; key_op = 3'd0; end
                16'h0080: begin key_is_op = 1'b1; key_op = 3'd1; end
                16'h0800: begin key_is_op = 1'b1; key_op = 3'd2; end
                16'h8000: begin key_is_op = 1'b1; key_op = 3'd3; end
                16'h4000: begin key_is_op = 1'b1; key_op = 3'd4; end
                16'h1000: key_is_eq = 1'b1;
                default: ;
            endcase
        end
    end

    // The display copy of the operand is kept in BCD by shifting in each typed digit.
    assign entry_next = {entry_bcd_reg[19:0], key_digit};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_dd_adj
            assign dd_adj[gi*4 +: 4] = (dd_bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                       dd_bcd_reg[gi*4 +: 4] + 4'd3 : dd_bcd_reg[gi*4 +: 4];
        end
    endgenerate
    assign dd_bcd_next = {dd_adj[22:0], dd_bin_reg[19]};

    function automatic logic [9:0] acc(input logic [9:0] v, input logic [3:0] d);
        logic [13:0] t;
        t = {4'd0, v} * 14'd10 + {10'd0, d};
        return t[9:0];
    endfunction

    // Digit 0 stays lit; higher digits blank while they and everything above are zero.
    function automatic logic [5:0] blank_of(input logic [23:0] b);
        logic       seen;
        logic [5:0] m;
        seen = 1'b0;
        m    = 6'b000000;
        for (int i = 5; i >= 1; i--) begin
            seen = seen | (b[i*4 +: 4] != 4'd0);
            m[i] = ~seen;
        end
        return m;
    endfunction

    always_ff @(posedge clock_50m) begin
        if (rst) begin
            state_reg     <= ENTER_A;
            a_reg         <= '0;
            b_reg         <= '0;
            a_cnt_reg     <= '0;
            b_cnt_reg     <= '0;
            op_reg        <= '0;
            entry_bcd_reg <= '0;
            timer_reg     <= '0;
            res_reg       <= '0;
            res_neg_reg   <= 1'b0;
            dd_bin_reg    <= '0;
            dd_bcd_reg    <= '0;
            dd_cnt_reg    <= '0;
            alu_start     <= 1'b0;
            alu_op        <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            disp_bcd      <= '0;
            disp_blank    <= 6'b111110;
            disp_mode     <= 2'd0;
            disp_op       <= '0;
            disp_neg      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            case (state_reg)
                ENTER_A: begin
                    if (key_is_digit && a_cnt_reg < CW'(MAX_DIGITS)) begin
                        a_reg         <= acc(a_reg, key_digit);
                        a_cnt_reg     <= a_cnt_reg + CW'(1);
                        entry_bcd_reg <= entry_next;
                        disp_bcd      <= entry_next;
                        disp_blank    <= blank_of(entry_next);
                        disp_mode     <= 2'd0;
                        disp_neg      <= 1'b0;
                    end else if (key_is_op) begin
                        op_reg        <= key_op;
                        b_reg         <= '0;
                        b_cnt_reg     <= '0;
                        entry_bcd_reg <= '0;
                        state_reg     <= ENTER_B;
                        disp_mode     <= 2'd1;
                        disp_op       <= key_op;
                        disp_neg      <= 1'b0;
                    end
                end
                ENTER_B: begin
                    if (key_is_digit && b_cnt_reg < CW'(MAX_DIGITS)) begin
                        b_reg         <= acc(b_reg, key_digit);
                        b_cnt_reg     <= b_cnt_reg + CW'(1);
                        entry_bcd_reg <= entry_next;
                        disp_bcd      <= entry_next;
                        disp_blank    <= blank_of(entry_next);
                        disp_mode     <= 2'd0;
                        disp_neg      <= 1'b0;
                    end else if (key_is_op && b_cnt_reg == '0) begin
                        op_reg  <= key_op;
                        disp_op <= key_op;
                    end else if (key_is_eq && b_cnt_reg != '0) begin
                        state_reg <= EXEC;
                        alu_start <= 1'b1;
                        alu_op    <= op_reg;
                        alu_a     <= a_reg;
                        alu_b     <= b_reg;
                        busy      <= 1'b1;
                        timer_reg <= '0;
                    end
                end
                EXEC: begin
                    // A done arriving on the expiry cycle takes precedence over the timeout.
                    if (alu_done) begin
                        if (alu_err) begin
                            state_reg <= ERR;
                            busy      <= 1'b0;
                            disp_mode <= 2'd2;
                            disp_neg  <= 1'b0;
                        end else begin
                            res_reg     <= alu_result;
                            res_neg_reg <= alu_neg;
                            dd_bin_reg  <= alu_result;
                            dd_bcd_reg  <= '0;
                            dd_cnt_reg  <= '0;
                            state_reg   <= CONV;
                        end
                    end else if (timer_reg == TW'(ALU_TIMEOUT - 1)) begin
                        state_reg <= ERR;
                        busy      <= 1'b0;
                        disp_mode <= 2'd2;
                        disp_neg  <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                CONV: begin
                    dd_bcd_reg <= dd_bcd_next;
                    dd_bin_reg <= {dd_bin_reg[18:0], 1'b0};
                    dd_cnt_reg <= dd_cnt_reg + 5'd1;
                    if (dd_cnt_reg == 5'd19) begin
                        state_reg  <= SHOW;
                        busy       <= 1'b0;
                        disp_bcd   <= dd_bcd_next;
                        disp_blank <= blank_of(dd_bcd_next);
                        disp_mode  <= 2'd0;
                        disp_neg   <= res_neg_reg;
                    end
                end
                SHOW, ERR: begin
                    if (key_is_digit) begin
                        a_reg         <= {6'd0, key_digit};
                        a_cnt_reg     <= CW'(1);
                        b_reg         <= '0;
                        b_cnt_reg     <= '0;
                        entry_bcd_reg <= {20'd0, key_digit};
                        state_reg     <= ENTER_A;
                        disp_bcd      <= {20'd0, key_digit};
                        disp_blank    <= 6'b111110;
                        disp_mode     <= 2'd0;
                        disp_neg      <= 1'b0;
                    end else if (key_is_op && state_reg == SHOW && !res_neg_reg
                                 && res_reg <= 20'd999) begin
                        a_reg         <= res_reg[9:0];
                        op_reg        <= key_op;
                        b_reg         <= '0;
                        b_cnt_reg     <= '0;
                        entry_bcd_reg <= '0;
                        state_reg     <= ENTER_B;
                        disp_mode     <= 2'd1;
                        disp_op       <= key_op;
                        disp_neg      <= 1'b0;
                    end
                end
                default: state_reg <= ENTER_A;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: ALU requests and display results go through
// scoreboard queues that are filled when stimulus is driven and drained on DUT output.
module tb_calc_sequencer;
    logic        clock_50m = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [15:0] key_code = '0;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [9:0]  alu_a, alu_b;
    logic        alu_done = 1'b0;
    logic [19:0] alu_result = '0;
    logic        alu_neg = 1'b0;
    logic        alu_err = 1'b0;
    logic [23:0] disp_bcd;
    logic [5:0]  disp_blank;
    logic [1:0]  disp_mode;
    logic [2:0]  disp_op;
    logic        disp_neg;
    logic        busy;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] K_ADD = 16'h0008, K_SUB = 16'h0080, K_MUL = 16'h0800,
                            K_DIV = 16'h8000, K_MOD = 16'h4000, K_EQ  = 16'h1000;

    typedef struct { logic [2:0] op; logic [9:0] a; logic [9:0] b; } alu_exp_t;
    typedef struct { logic [23:0] bcd; logic [5:0] blank; logic neg; } disp_exp_t;
    alu_exp_t  alu_q[$];
    disp_exp_t disp_q[$];

    calc_sequencer #(.MAX_DIGITS(3), .ALU_TIMEOUT(1024)) dut (
        .clock_50m(clock_50m), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_neg(alu_neg), .alu_err(alu_err),
        .disp_bcd(disp_bcd), .disp_blank(disp_blank), .disp_mode(disp_mode),
        .disp_op(disp_op), .disp_neg(disp_neg), .busy(busy)
    );

    always #5 clock_50m = ~clock_50m;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    function automatic logic [15:0] dkey(input int d);
        case (d)
            0: return 16'h2000;  1: return 16'h0001;  2: return 16'h0002;
            3: return 16'h0004;  4: return 16'h0010;  5: return 16'h0020;
            6: return 16'h0040;  7: return 16'h0100;  8: return 16'h0200;
            default: return 16'h0400;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [15:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clock_50m);
        key_valid = 1'b0;
        key_code  = '0;
        $display("key %04h -> bcd=%06h blank=%06b mode=%0d op=%0d neg=%0d busy=%0d",
                 k, disp_bcd, disp_blank, disp_mode, disp_op, disp_neg, busy);
    endtask

    // Press equals and match the resulting start pulse against the queued request.
    task automatic equals_start(input logic [2:0] op, input logic [9:0] a, input logic [9:0] b);
        alu_exp_t e;
        int n;
        alu_q.push_back('{op: op, a: a, b: b});
        press(K_EQ);
        n = 0;
        while (!alu_start && n < 20) begin
            @(negedge clock_50m);
            n++;
        end
        chk("start_seen", {31'd0, alu_start}, 32'd1);
        chk("start_latency", n, 0);
        e = alu_q.pop_front();
        chk("alu_op", {29'd0, alu_op}, {29'd0, e.op});
        chk("alu_a", {22'd0, alu_a}, {22'd0, e.a});
        chk("alu_b", {22'd0, alu_b}, {22'd0, e.b});
        chk("busy_exec", {31'd0, busy}, 32'd1);
        $display("alu start op=%0d a=%0d b=%0d", alu_op, alu_a, alu_b);
        @(negedge clock_50m);
        chk("start_one_cycle", {31'd0, alu_start}, 32'd0);
    endtask

    task automatic alu_reply(input logic [19:0] res, input logic neg, input logic err,
                             input int delay);
        repeat (delay) @(negedge clock_50m);
        alu_result = res;
        alu_neg    = neg;
        alu_err    = err;
        alu_done   = 1'b1;
        @(negedge clock_50m);
        alu_done = 1'b0;
        alu_err  = 1'b0;
        alu_neg  = 1'b0;
        $display("alu done result=%0d neg=%0d err=%0d", res, neg, err);
    endtask

    // Reply from the ALU and check the display appears exactly 21 cycles after done.
    task automatic conv_result(input logic [19:0] res, input logic neg, input int delay);
        disp_exp_t  e;
        logic [23:0] b;
        logic [5:0]  ones;
        int v, nd;
        b = '0;
        v = int'(res);
        for (int i = 0; i < 6; i++) begin
            b[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        nd = 1;
        v  = int'(res);
        while (v >= 10) begin
            v = v / 10;
            nd++;
        end
        ones = 6'b111111;
        disp_q.push_back('{bcd: b, blank: ones << nd, neg: neg});
        alu_reply(res, neg, 1'b0, delay);
        repeat (19) @(negedge clock_50m);
        chk("conv_busy_m20", {31'd0, busy}, 32'd1);
        @(negedge clock_50m);
        e = disp_q.pop_front();
        chk("show_busy", {31'd0, busy}, 32'd0);
        chk("show_bcd", {8'd0, disp_bcd}, {8'd0, e.bcd});
        chk("show_blank", {26'd0, disp_blank}, {26'd0, e.blank});
        chk("show_neg", {31'd0, disp_neg}, {31'd0, e.neg});
        chk("show_mode", {30'd0, disp_mode}, 32'd0);
        $display("show bcd=%06h blank=%06b neg=%0d", disp_bcd, disp_blank, disp_neg);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, {31'd0, alu_start}, 32'd0);
        chk({tag, "_op"}, {29'd0, alu_op}, 32'd0);
        chk({tag, "_a"}, {22'd0, alu_a}, 32'd0);
        chk({tag, "_b"}, {22'd0, alu_b}, 32'd0);
        chk({tag, "_bcd"}, {8'd0, disp_bcd}, 32'd0);
        chk({tag, "_blank"}, {26'd0, disp_blank}, 32'b111110);
        chk({tag, "_mode"}, {30'd0, disp_mode}, 32'd0);
        chk({tag, "_dop"}, {29'd0, disp_op}, 32'd0);
        chk({tag, "_neg"}, {31'd0, disp_neg}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int starts;
        repeat (3) @(negedge clock_50m);
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Add: 12 + 7, busy keys ignored, result 19.
        press(dkey(1));
        chk("a1_bcd", {8'd0, disp_bcd}, 32'h1);
        press(dkey(2));
        chk("a12_bcd", {8'd0, disp_bcd}, 32'h12);
        chk("a12_blank", {26'd0, disp_blank}, 32'b111100);
        press(K_ADD);
        chk("add_mode", {30'd0, disp_mode}, 32'd1);
        chk("add_dop", {29'd0, disp_op}, 32'd0);
        press(dkey(7));
        chk("b7_bcd", {8'd0, disp_bcd}, 32'h7);
        chk("b7_mode", {30'd0, disp_mode}, 32'd0);
        equals_start(3'd0, 10'd12, 10'd7);
        press(dkey(5));
        press(K_MUL);
        chk("exec_key_bcd", {8'd0, disp_bcd}, 32'h7);
        chk("exec_key_a", {22'd0, alu_a}, 32'd12);
        chk("exec_key_busy", {31'd0, busy}, 32'd1);
        conv_result(20'd19, 1'b0, 1);

        // Digit limit: 9999 keeps 999; then 999 + 1 gives 1000, which cannot chain.
        press(dkey(9));
        press(dkey(9));
        press(dkey(9));
        chk("a999_bcd", {8'd0, disp_bcd}, 32'h999);
        chk("a999_blank", {26'd0, disp_blank}, 32'b111000);
        press(dkey(9));
        chk("a9999_bcd", {8'd0, disp_bcd}, 32'h999);
        press(K_ADD);
        press(dkey(1));
        equals_start(3'd0, 10'd999, 10'd1);
        conv_result(20'd1000, 1'b0, 3);
        press(K_SUB);
        chk("chain1000_mode", {30'd0, disp_mode}, 32'd0);
        chk("chain1000_bcd", {8'd0, disp_bcd}, 32'h1000);

        // Operator replacement and negative result.
        press(dkey(5));
        chk("new_a5_bcd", {8'd0, disp_bcd}, 32'h5);
        press(K_MUL);
        chk("mul_dop", {29'd0, disp_op}, 32'd2);
        press(K_SUB);
        chk("replace_dop", {29'd0, disp_op}, 32'd1);
        chk("replace_mode", {30'd0, disp_mode}, 32'd1);
        press(dkey(8));
        equals_start(3'd1, 10'd5, 10'd8);
        conv_result(20'd3, 1'b1, 2);
        press(K_SUB);
        chk("neg_chain_mode", {30'd0, disp_mode}, 32'd0);
        chk("neg_chain_neg", {31'd0, disp_neg}, 32'd1);

        // Divide by zero reported by the ALU.
        press(dkey(4));
        press(K_DIV);
        press(dkey(0));
        chk("b0_blank", {26'd0, disp_blank}, 32'b111110);
        equals_start(3'd3, 10'd4, 10'd0);
        alu_reply(20'd0, 1'b0, 1'b1, 2);
        chk("err_mode", {30'd0, disp_mode}, 32'd2);
        chk("err_busy", {31'd0, busy}, 32'd0);
        press(K_MOD);
        chk("err_op_ignored", {30'd0, disp_mode}, 32'd2);
        alu_reply(20'd5, 1'b0, 1'b0, 0);
        chk("stray_done_mode", {30'd0, disp_mode}, 32'd2);
        chk("stray_done_busy", {31'd0, busy}, 32'd0);
        press(dkey(6));
        chk("err_digit_mode", {30'd0, disp_mode}, 32'd0);
        chk("err_digit_bcd", {8'd0, disp_bcd}, 32'h6);

        // Timeout: A=6 carried in, done withheld.
        press(K_ADD);
        press(dkey(2));
        equals_start(3'd0, 10'd6, 10'd2);
        repeat (1022) @(negedge clock_50m);
        chk("timeout_early_busy", {31'd0, busy}, 32'd1);
        chk("timeout_early_mode", {30'd0, disp_mode}, 32'd0);
        @(negedge clock_50m);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_mode", {30'd0, disp_mode}, 32'd2);

        // Chaining a 999 result into mod.
        press(dkey(9));
        press(dkey(9));
        press(dkey(0));
        press(K_ADD);
        press(dkey(9));
        equals_start(3'd0, 10'd990, 10'd9);
        conv_result(20'd999, 1'b0, 4);
        press(K_MOD);
        chk("chain_mode", {30'd0, disp_mode}, 32'd1);
        chk("chain_dop", {29'd0, disp_op}, 32'd4);
        press(dkey(3));
        equals_start(3'd4, 10'd999, 10'd3);
        conv_result(20'd0, 1'b0, 2);

        // Reset in the middle of conversion.
        press(dkey(1));
        press(K_ADD);
        press(dkey(1));
        equals_start(3'd0, 10'd1, 10'd1);
        alu_reply(20'd2, 1'b0, 1'b0, 1);
        repeat (5) @(negedge clock_50m);
        chk("conv_busy_pre_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clock_50m);
        chk_reset_outputs("conv_rst");
        rst = 1'b0;
        starts = 0;
        repeat (40) begin
            @(negedge clock_50m);
            if (alu_start) starts++;
        end
        chk("no_start_after_rst", starts, 0);
        chk("idle_after_rst_bcd", {8'd0, disp_bcd}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
